// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencer: ALU op/shift codes, FSM states and the ALU key helper.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_PASS_A = 3'b000,
    OP_ADD    = 3'b001,
    OP_SUB    = 3'b010,
    OP_AND    = 3'b011,
    OP_OR     = 3'b100,
    OP_INC    = 3'b101,
    OP_DEC    = 3'b110,
    OP_PASS_B = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_L1   = 2'b01,
    SH_R1   = 2'b10,
    SH_ZERO = 2'b11
  } alu_shift_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } seq_state_e;

  localparam int unsigned KEY_W = 5;

  function automatic logic [KEY_W-1:0] mk_key(input alu_op_e op, input alu_shift_e sh);
    return {op, sh};
  endfunction

endpackage

// File: rtl/alu_seq_fsm.sv
// Sequencer control: IDLE/EXEC/RESP state register, remaining-step counter and handshake decode.
module alu_seq_fsm
  import alu_seq_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             rsp_ready,
  output logic             cmd_ready,
  output logic             busy,
  output logic             rsp_valid,
  output logic             exec_en,
  output logic             accept,
  output logic             load_rsp
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // load_rsp marks the edge on which the final accumulator value is captured for the response
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    accept   = 1'b0;
    load_rsp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          rem_d  = cmd_cnt;
          if (cmd_cnt == '0) begin
            state_d  = S_RESP;
            load_rsp = 1'b1;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        rem_d = rem_q - 1'b1;
        if (rem_q == CNT_W'(1)) begin
          state_d  = S_RESP;
          load_rsp = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign exec_en   = (state_q == S_EXEC);

endmodule

// File: rtl/alu_seq_ctrl.sv
// Accumulator-based sequencer driving an external combinational ALU for cnt steps per command.
// Optional ALU_SEQ_FLAGS_EN adds registered rsp_zero/rsp_neg response flags.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [1:0]       cmd_shift,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             cmd_clr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [KEY_W-1:0] alu_key,
  input  logic [WIDTH-1:0] alu_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic             rsp_zero,
  output logic             rsp_neg
`endif
);

  logic             exec_en, accept, load_rsp;
  logic [WIDTH-1:0] acc_q, acc_d, b_q;
  alu_op_e          op_q;
  alu_shift_e       sh_q;

  alu_seq_fsm #(
    .CNT_W(CNT_W)
  ) u_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_cnt  (cmd_cnt),
    .rsp_ready(rsp_ready),
    .cmd_ready(cmd_ready),
    .busy     (busy),
    .rsp_valid(rsp_valid),
    .exec_en  (exec_en),
    .accept   (accept),
    .load_rsp (load_rsp)
  );

  // acc_d is what the accumulator becomes on this edge; the response capture uses it so
  // rsp_data already holds the final value in the first RESP cycle
  always_comb begin
    acc_d = acc_q;
    if (accept && cmd_clr) acc_d = '0;
    else if (exec_en)      acc_d = alu_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      b_q      <= '0;
      op_q     <= OP_PASS_A;
      sh_q     <= SH_NONE;
      rsp_data <= '0;
    end else begin
      acc_q <= acc_d;
      if (accept) begin
        b_q  <= cmd_b;
        op_q <= alu_op_e'(cmd_op);
        sh_q <= alu_shift_e'(cmd_shift);
      end
      if (load_rsp) rsp_data <= acc_d;
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_zero <= 1'b0;
      rsp_neg  <= 1'b0;
    end else if (load_rsp) begin
      rsp_zero <= (acc_d == '0);
      rsp_neg  <= acc_d[WIDTH-1];
    end
  end
`endif

  assign alu_a   = acc_q;
  assign alu_b   = b_q;
  assign alu_key = exec_en ? mk_key(op_q, sh_q) : '0;

endmodule
